// File: rtl/instr_sequencer_if.sv
// Handshake and control bundle between the sequencer and its surroundings
// (top-level Start/Done, instruction ROM, control decoder, ALU, data memory).
interface instr_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 6,
    parameter int CNT_W = 16
);
    logic             Start;
    logic [PC_W-1:0]  StartAddr;
    logic             Branch;
    logic             Taken;
    logic [OFF_W-1:0] BranchOff;
    logic             MemAccess;
    logic             MemReady;
    logic             Halt;
    logic [PC_W-1:0]  ProgCtr;
    logic             ExecEn;
    logic             Done;
    logic [CNT_W-1:0] CycleCount;

    modport slave (
        input  Start, StartAddr, Branch, Taken, BranchOff, MemAccess, MemReady, Halt,
        output ProgCtr, ExecEn, Done, CycleCount
    );

    modport master (
        output Start, StartAddr, Branch, Taken, BranchOff, MemAccess, MemReady, Halt,
        input  ProgCtr, ExecEn, Done, CycleCount
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns the PC, issues the single commit
// strobe, stalls on data-memory handshakes and resolves bne branches.
module instr_sequencer #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 6,
    parameter int CNT_W = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    instr_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEMWAIT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pc_step;
    logic [PC_W-1:0]  off_ext;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exec_en;

    // Offset is sign-extended to PC width; the add wraps silently.
    assign off_ext = {{(PC_W-OFF_W){bus.BranchOff[OFF_W-1]}}, bus.BranchOff};
    assign pc_step = (bus.Branch && bus.Taken) ? (pc_q + off_ext)
                                               : (pc_q + PC_W'(1));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        exec_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = S_FETCH;
                    pc_d    = bus.StartAddr;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Halt wins over both the memory stall and any branch.
                if (bus.Halt) begin
                    state_d = S_DONE;
                end else if (bus.MemAccess && !bus.MemReady) begin
                    state_d = S_MEMWAIT;
                end else begin
                    exec_en = 1'b1;
                    pc_d    = pc_step;
                    state_d = S_FETCH;
                end
            end
            S_MEMWAIT: begin
                if (bus.MemReady) begin
                    exec_en = 1'b1;
                    pc_d    = pc_step;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                if (!bus.Start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q == S_FETCH || state_q == S_EXEC || state_q == S_MEMWAIT)
            && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ProgCtr    = pc_q;
    assign bus.ExecEn     = exec_en;
    assign bus.Done       = done_q;
    assign bus.CycleCount = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised program runs against an instruction-level reference model;
// a negedge monitor checks every commit and the final Done state from a queue.
module tb_instr_sequencer;
    localparam int PC_W  = 10;
    localparam int OFF_W = 6;
    localparam int CNT_W = 16;
    localparam int DEPTH = 1 << PC_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_sequencer_if #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) bus ();

    instr_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    // Program image as seen through ROM + decoder + ALU, indexed by PC.
    bit r_halt [DEPTH];
    bit r_br   [DEPTH];
    bit r_tk   [DEPTH];
    bit r_mem  [DEPTH];
    int r_off  [DEPTH];
    int r_w    [DEPTH];

    typedef struct {
        int pc;
        int nxt;
        int cyc;
    } commit_t;

    commit_t exp_q[$];
    commit_t mon_e;
    int  exp_halt_pc;
    int  exp_total;
    int  exp_total_raw;
    bit  run_active = 1'b0;
    bit  done_seen  = 1'b0;
    bit  pend_next  = 1'b0;
    int  pend_pc;
    int  cyc;
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) begin
            r_halt[i] = 0; r_br[i] = 0; r_tk[i] = 0; r_mem[i] = 0;
            r_off[i] = 0;  r_w[i] = 0;
        end
    endtask

    task automatic random_rom();
        for (int i = 0; i < DEPTH; i++) begin
            r_halt[i] = ($urandom_range(0, 15) == 0);
            r_br[i]   = ($urandom_range(0, 2) == 0);
            r_tk[i]   = $urandom_range(0, 1) == 1;
            r_off[i]  = $urandom_range(0, 63) - 32;
            r_mem[i]  = ($urandom_range(0, 3) == 0);
            r_w[i]    = $urandom_range(0, 4);
        end
    endtask

    // Walk the program instruction by instruction from the rules.
    task automatic model_run(input int start, output bit halted, output int stop_pc);
        int pc;
        int nxt;
        pc = start;
        halted = 0;
        exp_q.delete();
        exp_total_raw = 0;
        for (int n = 0; n < 40; n++) begin
            if (r_halt[pc]) begin
                halted = 1;
                break;
            end
            if (r_br[pc] && r_tk[pc]) nxt = (((pc + r_off[pc]) % DEPTH) + DEPTH) % DEPTH;
            else                      nxt = (pc + 1) % DEPTH;
            exp_total_raw += 2 + (r_mem[pc] ? r_w[pc] : 0);
            exp_q.push_back('{pc: pc, nxt: nxt, cyc: exp_total_raw});
            pc = nxt;
        end
        stop_pc = pc;
        exp_halt_pc = pc;
        exp_total_raw += 2;
        exp_total = (exp_total_raw > CMAX) ? CMAX : exp_total_raw;
    endtask

    task automatic prepare(input int start);
        bit halted;
        int stop_pc;
        model_run(start, halted, stop_pc);
        if (!halted) begin
            r_halt[stop_pc] = 1;
            model_run(start, halted, stop_pc);
        end
    endtask

    task automatic drive(input int since);
        int pc;
        pc = int'(bus.ProgCtr);
        bus.Halt      = r_halt[pc];
        bus.Branch    = r_br[pc];
        bus.Taken     = r_tk[pc];
        bus.BranchOff = OFF_W'(r_off[pc]);
        bus.MemAccess = r_mem[pc];
        bus.MemReady  = r_mem[pc] ? (since >= 1 + r_w[pc]) : ($urandom_range(0, 1) == 1);
        bus.Start     = r_halt[pc] ? 1'b1 : ($urandom_range(0, 1) == 1);
        bus.StartAddr = PC_W'($urandom);
    endtask

    // Called at posedge+1 with the DUT in IDLE.
    task automatic run_program(input int start);
        int  since;
        bit  ev;
        int  hold;
        prepare(start);
        $display("[TB] run start=%0d commits=%0d halt_pc=%0d cycles=%0d",
                 start, exp_q.size(), exp_halt_pc, exp_total);
        bus.StartAddr = PC_W'(start);
        bus.Start     = 1'b1;
        @(posedge clk);
        run_active = 1'b1;
        done_seen  = 1'b0;
        pend_next  = 1'b0;
        cyc        = 0;
        since      = 0;
        #1 drive(since);
        for (int k = 0; k < 3000 && !done_seen; k++) begin
            @(negedge clk);
            ev = bus.ExecEn;
            @(posedge clk);
            since = ev ? 0 : since + 1;
            #1 drive(since);
        end
        if (!done_seen) begin
            check("run_timeout", 0, 1);
            run_active = 1'b0;
            rst = 1'b1;
            #2 rst = 1'b0;
            @(posedge clk); #1;
            return;
        end
        hold = $urandom_range(1, 3);
        repeat (hold) begin
            @(negedge clk);
            check("done_hold", bus.Done, 1);
            check("count_hold_done", bus.CycleCount, exp_total);
            @(posedge clk); #1;
        end
        bus.Start = 1'b0;
        @(negedge clk);
        check("done_before_drop", bus.Done, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_drop", bus.Done, 0);
        check("count_hold_idle", bus.CycleCount, exp_total);
        check("pc_hold_idle", bus.ProgCtr, exp_halt_pc);
        run_active = 1'b0;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (run_active && !rst) begin
            cyc++;
            if (pend_next) begin
                check("next_pc", bus.ProgCtr, pend_pc);
                pend_next = 1'b0;
            end
            if (bus.ExecEn) begin
                if (exp_q.size() == 0) begin
                    check("extra_commit", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("[TB] commit pc=%0d -> %0d at cycle %0d", mon_e.pc, mon_e.nxt, cyc);
                    check("commit_pc", bus.ProgCtr, mon_e.pc);
                    check("commit_cycle", cyc, mon_e.cyc);
                    pend_next = 1'b1;
                    pend_pc   = mon_e.nxt;
                end
            end
            if (bus.Done && !done_seen) begin
                done_seen = 1'b1;
                $display("[TB] done pc=%0d count=%0d", bus.ProgCtr, bus.CycleCount);
                check("halt_pc", bus.ProgCtr, exp_halt_pc);
                check("cycle_count", bus.CycleCount, exp_total);
                check("done_cycle", cyc, exp_total_raw + 1);
                check("missing_commits", exp_q.size(), 0);
            end
        end
    end

    initial begin
        bus.Start = 0; bus.StartAddr = '0; bus.Branch = 0; bus.Taken = 0;
        bus.BranchOff = '0; bus.MemAccess = 0; bus.MemReady = 0; bus.Halt = 0;
        #2;
        check("rst_pc", bus.ProgCtr, 0);
        check("rst_exec", bus.ExecEn, 0);
        check("rst_done", bus.Done, 0);
        check("rst_count", bus.CycleCount, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Straight-line run from 2 halting at 12.
        clear_rom();
        r_halt[12] = 1;
        run_program(2);

        // Taken branch -3, 3-cycle memory stall, untaken branch, halt.
        clear_rom();
        r_br[8] = 1; r_tk[8] = 1; r_off[8] = -3;
        r_mem[5] = 1; r_w[5] = 3;
        r_br[6] = 1; r_tk[6] = 0; r_off[6] = -3;
        r_halt[7] = 1;
        run_program(8);

        // Wrap at bottom (1 - 2 -> 1023) and at top (1023 -> 0).
        clear_rom();
        r_br[1] = 1; r_tk[1] = 1; r_off[1] = -2;
        r_halt[0] = 1;
        run_program(1);

        // Halt carrying branch and memory flags must still just halt.
        clear_rom();
        r_halt[40] = 1; r_br[40] = 1; r_tk[40] = 1; r_off[40] = 5;
        r_mem[40] = 1; r_w[40] = 4;
        run_program(39);

        for (int t = 0; t < 8; t++) begin
            random_rom();
            run_program($urandom_range(0, DEPTH - 1));
        end

        // Asynchronous reset in the middle of a memory stall.
        clear_rom();
        r_mem[300] = 1;
        bus.StartAddr = PC_W'(300);
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.Halt = 0; bus.Branch = 0; bus.Taken = 0;
        bus.MemAccess = 1; bus.MemReady = 0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_count", bus.CycleCount, 3);
        check("pre_reset_pc", bus.ProgCtr, 300);
        check("memwait_exec", bus.ExecEn, 0);
        #2 rst = 1'b1;
        #1;
        $display("[TB] async reset mid-wait pc=%0d count=%0d", bus.ProgCtr, bus.CycleCount);
        check("async_rst_pc", bus.ProgCtr, 0);
        check("async_rst_exec", bus.ExecEn, 0);
        check("async_rst_done", bus.Done, 0);
        check("async_rst_count", bus.CycleCount, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.MemAccess = 0;
        @(posedge clk); #1;
        clear_rom();
        r_halt[20] = 1;
        run_program(17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
